// File: rtl/pwm_meter_pkg.sv
// Shared types and widths for the PWM generator/meter pair.
package pwm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_e;

  localparam int unsigned W_DEFAULT = 16;

endpackage

// File: rtl/pwm_meter_if.sv
// Measurement bus: the PWM line in, per-cycle period/high results out.
interface pwm_meter_if #(
  parameter int unsigned W = pwm_pkg::W_DEFAULT
);

  logic         pwm_in;
  logic [W-1:0] period;
  logic [W-1:0] high;
  logic         ovf;
  logic         valid;

  modport master (output pwm_in, input period, high, ovf, valid);
  modport slave  (input pwm_in, output period, high, ovf, valid);

endinterface

// File: rtl/pwm_meter_edge_detect.sv
// Optional synchroniser followed by rise/fall detection of a single line.
module edge_detect #(
  parameter int unsigned SYNC_STAGES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic s_c;
  logic prev_q;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s_c = d_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // Reset high so a line already high at release looks settled, not rising
      always_ff @(posedge clk) begin
        if (rst) sync_q <= '1;
        else     sync_q <= (sync_q << 1) | SYNC_STAGES'(d_i);
      end

      assign s_c = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= s_c;
  end

  assign rise_c_o = s_c & ~prev_q;
  assign fall_c_o = ~s_c & prev_q;

endmodule

// File: rtl/pwm_meter.sv
// Measures period and high time of each PWM cycle; one valid strobe per result.
module pwm_meter
  import pwm_pkg::*;
#(
  parameter int unsigned W           = W_DEFAULT,
  parameter int unsigned SYNC_STAGES = 0
) (
  input logic        clk,
  input logic        rst,
  pwm_meter_if.slave bus
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic         rise_c;
  logic         fall_c;
  state_e       state_q;
  logic [W-1:0] cnt_q;
  logic [W-1:0] hi_lat_q;
  logic [W-1:0] period_q;
  logic [W-1:0] high_q;
  logic         ovf_q;
  logic         valid_q;

  edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
    .clk      (clk),
    .rst      (rst),
    .d_i      (bus.pwm_in),
    .rise_c_o (rise_c),
    .fall_c_o (fall_c)
  );

  // cnt reads j on the j-th cycle after the rise; timeout fires before it can wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_lat_q <= '0;
      period_q <= '0;
      high_q   <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (rise_c) begin
            cnt_q   <= W'(1);
            state_q <= MEAS;
          end
        end
        MEAS: begin
          if (rise_c) begin
            period_q <= cnt_q;
            high_q   <= hi_lat_q;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b1;
            cnt_q    <= W'(1);
          end else if (cnt_q == CNT_MAX) begin
            period_q <= '0;
            high_q   <= '0;
            ovf_q    <= 1'b1;
            valid_q  <= 1'b1;
            cnt_q    <= '0;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + W'(1);
            if (fall_c) hi_lat_q <= cnt_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.period = period_q;
  assign bus.high   = high_q;
  assign bus.ovf    = ovf_q;
  assign bus.valid  = valid_q;

endmodule

// File: tb/tb_pwm_meter.sv
// Directed bench: a 16-bit same-clock meter and an 8-bit two-stage-sync meter.
module tb_pwm_meter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   gen_cnt = 0;
  int   gen_top = 9;
  int   gen_cmp = 3;

  always #5 clk = ~clk;

  pwm_meter_if #(.W(16)) bus16 ();
  pwm_meter_if #(.W(8))  bus8 ();

  pwm_meter #(.W(16), .SYNC_STAGES(0)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  pwm_meter #(.W(8),  .SYNC_STAGES(2)) dut8  (.clk(clk), .rst(rst), .bus(bus8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic lvl);
    rst = 1'b1;
    bus16.pwm_in = lvl;
    bus8.pwm_in  = lvl;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    bus16.pwm_in = 1'b0;
    bus8.pwm_in  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic gen_step();
    bus16.pwm_in = (gen_cnt < gen_cmp);
    gen_cnt = (gen_cnt == gen_top) ? 0 : gen_cnt + 1;
    tick();
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    checks++; if (bus16.period !== 16'd0) begin errors++; $display("FAIL reset16_period got %0d want 0", bus16.period); end
    checks++; if (bus16.high   !== 16'd0) begin errors++; $display("FAIL reset16_high got %0d want 0", bus16.high); end
    checks++; if (bus16.ovf    !== 1'b0)  begin errors++; $display("FAIL reset16_ovf got %b want 0", bus16.ovf); end
    checks++; if (bus16.valid  !== 1'b0)  begin errors++; $display("FAIL reset16_valid got %b want 0", bus16.valid); end
    checks++; if (bus8.period  !== 8'd0)  begin errors++; $display("FAIL reset8_period got %0d want 0", bus8.period); end
    checks++; if (bus8.valid   !== 1'b0)  begin errors++; $display("FAIL reset8_valid got %b want 0", bus8.valid); end
    idle(4);
  endtask

  // top=9, cmp=3: rises every 10 cycles; first rise only arms
  task automatic test_gen_steady();
    int nval = 0;
    int last = -1;
    gen_cnt = 0; gen_top = 9; gen_cmp = 3;
    for (int c = 0; c < 60; c++) begin
      gen_step();
      if (bus16.valid === 1'b1) begin
        nval++;
        checks++;
        if (bus16.period !== 16'd10 || bus16.high !== 16'd3 || bus16.ovf !== 1'b0) begin
          errors++;
          $display("FAIL gen_steady_value got p=%0d h=%0d o=%b want p=10 h=3 o=0", bus16.period, bus16.high, bus16.ovf);
        end
        if (last >= 0) begin
          checks++;
          if (c - last != 10) begin errors++; $display("FAIL gen_steady_spacing got %0d want 10", c - last); end
        end
        last = c;
      end
    end
    checks++; if (nval != 5) begin errors++; $display("FAIL gen_steady_count got %0d want 5", nval); end
  endtask

  // cmp changed at a cycle boundary: first result is the old cycle, then 10/7
  task automatic test_cmp_change();
    int nval = 0;
    gen_cmp = 7;
    for (int c = 0; c < 50; c++) begin
      gen_step();
      if (bus16.valid === 1'b1) begin
        nval++;
        checks++;
        if (nval == 1) begin
          if (bus16.period !== 16'd10 || bus16.high !== 16'd3) begin
            errors++;
            $display("FAIL cmp_change_first got p=%0d h=%0d want p=10 h=3", bus16.period, bus16.high);
          end
        end else if (bus16.period !== 16'd10 || bus16.high !== 16'd7 || bus16.ovf !== 1'b0) begin
          errors++;
          $display("FAIL cmp_change_steady got p=%0d h=%0d o=%b want p=10 h=7 o=0", bus16.period, bus16.high, bus16.ovf);
        end
      end
    end
    checks++; if (nval != 5) begin errors++; $display("FAIL cmp_change_count got %0d want 5", nval); end
  endtask

  task automatic test_min_pattern();
    int nval = 0;
    do_reset(1'b0);
    idle(2);
    for (int c = 0; c < 20; c++) begin
      bus16.pwm_in = (c % 2 == 0);
      tick();
      if (bus16.valid === 1'b1) begin
        nval++;
        checks++;
        if (bus16.period !== 16'd2 || bus16.high !== 16'd1) begin
          errors++;
          $display("FAIL min_pattern_value got p=%0d h=%0d want p=2 h=1", bus16.period, bus16.high);
        end
      end
    end
    checks++; if (nval != 9) begin errors++; $display("FAIL min_pattern_count got %0d want 9", nval); end
  endtask

  task automatic test_reset_mid();
    bit pat1 [8]  = '{1, 1, 0, 0, 0, 1, 1, 0};
    bit pat2 [10] = '{0, 0, 1, 1, 1, 0, 1, 0, 0, 0};
    int nval = 0;
    do_reset(1'b0);
    idle(2);
    for (int c = 0; c < 8; c++) begin
      bus16.pwm_in = pat1[c];
      tick();
      if (bus16.valid === 1'b1) begin
        nval++;
        checks++;
        if (bus16.period !== 16'd5 || bus16.high !== 16'd2) begin
          errors++;
          $display("FAIL reset_mid_pre got p=%0d h=%0d want p=5 h=2", bus16.period, bus16.high);
        end
      end
    end
    checks++; if (nval != 1) begin errors++; $display("FAIL reset_mid_pre_count got %0d want 1", nval); end
    rst = 1'b1;
    bus16.pwm_in = 1'b0;
    tick();
    rst = 1'b0;
    checks++; if (bus16.valid !== 1'b0 || bus16.period !== 16'd0) begin
      errors++; $display("FAIL reset_mid_clear got v=%b p=%0d want v=0 p=0", bus16.valid, bus16.period);
    end
    nval = 0;
    for (int c = 0; c < 10; c++) begin
      bus16.pwm_in = pat2[c];
      tick();
      if (bus16.valid === 1'b1) begin
        nval++;
        checks++;
        if (c != 6 || bus16.period !== 16'd4 || bus16.high !== 16'd3) begin
          errors++;
          $display("FAIL reset_mid_post got c=%0d p=%0d h=%0d want c=6 p=4 h=3", c, bus16.period, bus16.high);
        end
      end
    end
    checks++; if (nval != 1) begin errors++; $display("FAIL reset_mid_post_count got %0d want 1", nval); end
  endtask

  task automatic test_high_at_reset();
    bit pat [9] = '{0, 0, 1, 1, 0, 0, 1, 0, 0};
    int early = 0;
    int nval = 0;
    do_reset(1'b1);
    for (int c = 0; c < 5; c++) begin
      bus16.pwm_in = 1'b1;
      tick();
      if (bus16.valid === 1'b1) early++;
    end
    for (int c = 0; c < 9; c++) begin
      bus16.pwm_in = pat[c];
      tick();
      if (bus16.valid === 1'b1) begin
        if (c < 6) early++;
        else begin
          nval++;
          checks++;
          if (c != 6 || bus16.period !== 16'd4 || bus16.high !== 16'd2) begin
            errors++;
            $display("FAIL high_at_reset_value got c=%0d p=%0d h=%0d want c=6 p=4 h=2", c, bus16.period, bus16.high);
          end
        end
      end
    end
    checks++; if (early != 0) begin errors++; $display("FAIL high_at_reset_spurious got %0d want 0", early); end
    checks++; if (nval != 1)  begin errors++; $display("FAIL high_at_reset_count got %0d want 1", nval); end
  endtask

  // W=8 behind a 2-flop synchroniser: timeout 255 cycles after the last rise
  task automatic test_timeout();
    bit pat [8] = '{1, 1, 0, 0, 0, 1, 1, 0};
    bit pat2 [4] = '{1, 0, 0, 1};
    int vcyc[$];
    logic [7:0] vper[$];
    logic [7:0] vhi[$];
    logic vovf[$];
    int late = 0;
    do_reset(1'b0);
    idle(4);
    for (int c = 0; c < 700; c++) begin
      bus8.pwm_in = (c < 8) ? pat[c] : 1'b0;
      tick();
      if (bus8.valid === 1'b1) begin
        vcyc.push_back(c); vper.push_back(bus8.period);
        vhi.push_back(bus8.high); vovf.push_back(bus8.ovf);
      end
    end
    checks++;
    if (vcyc.size() != 2) begin
      errors++; $display("FAIL timeout_count got %0d want 2", vcyc.size());
    end else begin
      checks++;
      if (vper[0] !== 8'd5 || vhi[0] !== 8'd2 || vovf[0] !== 1'b0) begin
        errors++; $display("FAIL timeout_first got p=%0d h=%0d o=%b want p=5 h=2 o=0", vper[0], vhi[0], vovf[0]);
      end
      checks++;
      if (vper[1] !== 8'd0 || vhi[1] !== 8'd0 || vovf[1] !== 1'b1) begin
        errors++; $display("FAIL timeout_ovf got p=%0d h=%0d o=%b want p=0 h=0 o=1", vper[1], vhi[1], vovf[1]);
      end
      checks++;
      if (vcyc[1] - vcyc[0] != 255) begin
        errors++; $display("FAIL timeout_gap got %0d want 255", vcyc[1] - vcyc[0]);
      end
    end
    for (int c = 0; c < 14; c++) begin
      bus8.pwm_in = (c < 4) ? pat2[c] : 1'b0;
      tick();
      if (bus8.valid === 1'b1) begin
        late++;
        checks++;
        if (bus8.period !== 8'd3 || bus8.high !== 8'd1 || bus8.ovf !== 1'b0) begin
          errors++; $display("FAIL timeout_recover got p=%0d h=%0d o=%b want p=3 h=1 o=0", bus8.period, bus8.high, bus8.ovf);
        end
      end
    end
    checks++; if (late != 1) begin errors++; $display("FAIL timeout_recover_count got %0d want 1", late); end
  endtask

  // Period of exactly 255: rise beats the timeout in the same cycle
  task automatic test_period_max();
    int nval = 0;
    idle(300);
    for (int c = 0; c < 270; c++) begin
      bus8.pwm_in = (c == 0 || c == 255);
      tick();
      if (bus8.valid === 1'b1) begin
        nval++;
        checks++;
        if (bus8.period !== 8'd255 || bus8.high !== 8'd1 || bus8.ovf !== 1'b0) begin
          errors++; $display("FAIL period_max_value got p=%0d h=%0d o=%b want p=255 h=1 o=0", bus8.period, bus8.high, bus8.ovf);
        end
      end
    end
    checks++; if (nval != 1) begin errors++; $display("FAIL period_max_count got %0d want 1", nval); end
  endtask

  initial begin
    bus16.pwm_in = 1'b0;
    bus8.pwm_in  = 1'b0;
    test_reset();
    test_gen_steady();
    test_cmp_change();
    test_min_pattern();
    test_reset_mid();
    test_high_at_reset();
    test_timeout();
    test_period_max();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_meter.md
Name: pwm_meter

Overview:
- Downstream stage of the team's 16-bit PWM generator. Consumes its `out` line and measures each PWM cycle.
- Measured values: period (clocks between consecutive rising edges) and high time (clocks from a rising edge to the following falling edge).
- Each completed measurement is presented with a one-cycle `valid` strobe. Lets a controller or bench confirm that programmed top/cmp values produce the intended waveform.

Parameters:
- W, 16, width of the period/high counters and result ports. Matches the generator counter width.
- SYNC_STAGES, 0, number of flip-flop stages on pwm_in before edge detection. Use 0 for a same-clock source, 2 for an asynchronous pin. Adds fixed latency only; reported values are unaffected.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- pwm_in  in  1  PWM waveform to measure, e.g. the generator `out`.
- period  out  W  last measured period in clk cycles.
- high  out  W  last measured high time in clk cycles.
- ovf  out  1  last result was a timeout (no rising edge within 2^W-1 cycles). Qualified by valid.
- valid  out  1  one-cycle strobe: period/high/ovf updated this cycle.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - period=0, high=0, ovf=0, valid=0.
  - state=IDLE, cnt=0, hi_lat=0.
  - The edge-detect previous-sample register resets to 1. A line already high at reset release therefore gives no spurious rising edge.
  - Reset mid-measurement discards the partial measurement; nothing is reported.
- Edge detection on s (pwm_in after SYNC_STAGES flops), with prev = s delayed one cycle:
  - rise = s & ~prev.
  - fall = ~s & prev.
- States:
  - IDLE: cnt held at 0, fall ignored. On rise: cnt<=1, go to MEAS. No valid is issued; the first edge only arms the meter.
  - MEAS, in priority order:
    1. rise: period<=cnt, high<=hi_lat, ovf<=0, valid<=1, cnt<=1, stay in MEAS.
    2. cnt == 2^W-1 with no rise: period<=0, high<=0, ovf<=1, valid<=1, cnt<=0, go to IDLE.
    3. Otherwise cnt<=cnt+1. On fall, also hi_lat<=cnt.
- Counting convention: cnt reads j on the j-th cycle after the rise cycle.
  - Generator with top=T, cmp=C (0<C<=T) yields period=T+1, high=C.
- Latency: result registered at the posedge after the detecting cycle. valid is high for exactly that one cycle and 0 otherwise. Outputs hold between strobes.
- Width rules:
  - cnt is W bits, unsigned, never wraps; the timeout check fires before wrap.
  - hi_lat <= cnt always, so high <= period.
- Boundaries:
  - Constant 0 or constant 1 on pwm_in, i.e. generator cmp=0 or cmp>top: in MEAS, timeout after 2^W-1 cycles. In IDLE, silent forever.
  - Period of exactly 2^W-1 is reported normally: rise takes priority over timeout in the same cycle.
  - Minimum measurable waveform: high time 1, period 2.

Decomposition:
- Package pwm_pkg:
  - state enum {IDLE, MEAS}.
  - localparam W_DEFAULT=16, shared with the generator.
- One sub-module: edge_detect. Contains the SYNC_STAGES flops, the prev register (reset value 1), and rise/fall outputs.
- Counter/FSM stays in pwm_meter.

Test Plan:
- Generator top=9, cmp=3 feeding pwm_in -> after arming, valid every 10 cycles with period=10, high=3, ovf=0.
- Change cmp 3->7 mid-run (top=9) -> at most one transitional result, then steady period=10, high=7.
- W=8, pwm_in held 0 after one full cycle -> exactly 255 cycles after the last rise: valid=1, ovf=1, period=0, high=0, then silent. Next two rises yield a normal result with ovf=0.
- Hand-driven pattern 1,0 repeating -> period=2, high=1 on every rise after the first.
- rst pulsed 3 cycles after a rise -> no valid for the discarded cycle. The first rise after reset arms only. The second rise reports correct values.
- pwm_in high during and after reset release -> no valid until a genuine 0->1 transition followed by a second rise.
